dly_sel_ctrl: RTL and testbench

- Parametrised successor to the delay-select address decoder.
- Accepts delay commands (load / increment / decrement) for an addressed channel over a valid/ready handshake and issues a one-cycle registered strobe to exactly one of NUM_CHAN delay-line channels.
- Keeps a saturating shadow tap count per channel, enforces a settle interval between commands, and rejects out-of-range addresses.
- Sits between the fabric delay-calibration logic and the I/O delay primitives.

---
 rtl/dly_sel_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dly_sel_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dly_sel_ctrl.sv
// Delay-select controller: accepts load/inc/dec commands for one addressed channel,
// issues a one-cycle one-hot strobe, tracks saturating shadow taps and enforces a settle gap.
module dly_sel_ctrl #(
    parameter int NUM_CHAN      = 20,
    parameter int ADDR_W        = 5,
    parameter int TAP_W         = 6,
    parameter int INIT_TAP      = 0,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [ADDR_W-1:0]   CMD_ADDR,
    input  logic [1:0]          CMD_OP,
    input  logic [TAP_W-1:0]    CMD_VALUE,
    output logic [NUM_CHAN-1:0] DLY_LOAD,
    output logic [NUM_CHAN-1:0] DLY_ADJ,
    output logic [NUM_CHAN-1:0] DLY_INCDEC,
    output logic [TAP_W-1:0]    DLY_LOAD_VALUE,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    output logic [TAP_W-1:0]    RD_TAP,
    output logic                ERR,
    output logic                SAT,
    output logic                BUSY
);

    // Handshake: a command transfers on the rising edge where CMD_VALID and CMD_READY
    // are both high; the fields are used only at that edge and ignored afterwards.

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0]     NUM_CHAN_L  = (ADDR_W + 1)'(NUM_CHAN);
    localparam logic [TAP_W-1:0]    INIT_L      = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0]    TAP_MAX     = '1;
    localparam logic [NUM_CHAN-1:0] ONE         = NUM_CHAN'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    settle_cnt;
    logic [TAP_W-1:0]    shadow [NUM_CHAN];

    logic                accept;
    logic                addr_ok;
    logic                rd_ok;
    logic [TAP_W-1:0]    cur_tap;
    logic                at_limit;
    logic                go_issue;

    always_comb begin
        accept   = CMD_VALID & CMD_READY;
        addr_ok  = {1'b0, CMD_ADDR} < NUM_CHAN_L;
        rd_ok    = {1'b0, RD_ADDR} < NUM_CHAN_L;
        cur_tap  = addr_ok ? shadow[CMD_ADDR] : '0;
        at_limit = ((CMD_OP == OP_INC) && (cur_tap == TAP_MAX)) ||
                   ((CMD_OP == OP_DEC) && (cur_tap == '0));
        go_issue = accept & addr_ok & (CMD_OP != OP_NOP) & ~at_limit;
    end

    // The strobe is registered on the accept edge, so it is high exactly while the FSM
    // sits in ISSUE, and the shadow tap moves on that same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            CMD_READY      <= 1'b0;
            BUSY           <= 1'b0;
            DLY_LOAD       <= '0;
            DLY_ADJ        <= '0;
            DLY_INCDEC     <= '0;
            DLY_LOAD_VALUE <= '0;
            RD_TAP         <= '0;
            ERR            <= 1'b0;
            SAT            <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                shadow[i] <= INIT_L;
            end
        end else begin
            DLY_LOAD       <= '0;
            DLY_ADJ        <= '0;
            DLY_INCDEC     <= '0;
            DLY_LOAD_VALUE <= '0;
            ERR            <= 1'b0;
            SAT            <= 1'b0;
            RD_TAP         <= rd_ok ? shadow[RD_ADDR] : '0;
            CMD_READY      <= 1'b0;
            BUSY           <= 1'b1;

            case (state)
                IDLE: begin
                    CMD_READY <= ~go_issue;
                    BUSY      <= go_issue;
                    if (accept) begin
                        if (!addr_ok) begin
                            ERR <= 1'b1;
                        end else if (at_limit) begin
                            SAT <= 1'b1;
                        end else if (go_issue) begin
                            state <= ISSUE;
                            case (CMD_OP)
                                OP_LOAD: begin
                                    DLY_LOAD         <= ONE << CMD_ADDR;
                                    DLY_LOAD_VALUE   <= CMD_VALUE;
                                    shadow[CMD_ADDR] <= CMD_VALUE;
                                end
                                OP_INC: begin
                                    DLY_ADJ          <= ONE << CMD_ADDR;
                                    DLY_INCDEC       <= ONE << CMD_ADDR;
                                    shadow[CMD_ADDR] <= cur_tap + TAP_W'(1);
                                end
                                OP_DEC: begin
                                    DLY_ADJ          <= ONE << CMD_ADDR;
                                    shadow[CMD_ADDR] <= cur_tap - TAP_W'(1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ISSUE: begin
                    settle_cnt <= '0;
                    if (SETTLE_CYCLES > 0) begin
                        state <= SETTLE;
                    end else begin
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end

                SETTLE: begin
                    // READY rises together with the return to IDLE, giving one
                    // command per 2+SETTLE_CYCLES edges.
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dly_sel_ctrl.sv
// Directed bench for dly_sel_ctrl: stimulus pushes expected strobe/pulse events into a
// queue, an independent monitor pops and compares whenever the DUT shows activity.
module tb_dly_sel_ctrl;

    localparam int NC   = 20;
    localparam int AW   = 5;
    localparam int TW   = 6;
    localparam int ST   = 3;
    localparam int EV_W = 3 * NC + TW + 2;

    localparam int OP_NOP  = 0;
    localparam int OP_LOAD = 1;
    localparam int OP_INC  = 2;
    localparam int OP_DEC  = 3;

    logic          CLK;
    logic          RST;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [AW-1:0] CMD_ADDR;
    logic [1:0]    CMD_OP;
    logic [TW-1:0] CMD_VALUE;
    logic [NC-1:0] DLY_LOAD;
    logic [NC-1:0] DLY_ADJ;
    logic [NC-1:0] DLY_INCDEC;
    logic [TW-1:0] DLY_LOAD_VALUE;
    logic [AW-1:0] RD_ADDR;
    logic [TW-1:0] RD_TAP;
    logic          ERR;
    logic          SAT;
    logic          BUSY;

    int tests = 0;
    int fails = 0;
    logic [EV_W-1:0] exp_q[$];

    dly_sel_ctrl #(
        .NUM_CHAN(NC), .ADDR_W(AW), .TAP_W(TW), .INIT_TAP(0), .SETTLE_CYCLES(ST)
    ) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_OP(CMD_OP), .CMD_VALUE(CMD_VALUE),
        .DLY_LOAD(DLY_LOAD), .DLY_ADJ(DLY_ADJ), .DLY_INCDEC(DLY_INCDEC),
        .DLY_LOAD_VALUE(DLY_LOAD_VALUE), .RD_ADDR(RD_ADDR), .RD_TAP(RD_TAP),
        .ERR(ERR), .SAT(SAT), .BUSY(BUSY)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected-event builders
    function automatic logic [EV_W-1:0] ev_load(input int ch, input int val);
        logic [NC-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        return {oh, {NC{1'b0}}, {NC{1'b0}}, TW'(val), 2'b00};
    endfunction

    function automatic logic [EV_W-1:0] ev_adj(input int ch, input bit inc);
        logic [NC-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        return {{NC{1'b0}}, oh, (inc ? oh : {NC{1'b0}}), {TW{1'b0}}, 2'b00};
    endfunction

    function automatic logic [EV_W-1:0] ev_flag(input bit err, input bit sat);
        return {{(3 * NC + TW){1'b0}}, err, sat};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Driver tasks (called and returning at a falling edge)
    task automatic wait_ready();
        int n;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_wait", 64'(CMD_READY), 64'd1);
    endtask

    task automatic send(input int a, input int op, input int val,
                        input logic [EV_W-1:0] exp, input bit has_ev);
        wait_ready();
        if (has_ev) exp_q.push_back(exp);
        CMD_VALID = 1'b1;
        CMD_ADDR  = AW'(a);
        CMD_OP    = 2'(op);
        CMD_VALUE = TW'(val);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_ADDR  = AW'($urandom_range(0, 31));
        CMD_OP    = 2'($urandom_range(0, 3));
        CMD_VALUE = TW'($urandom_range(0, 63));
    endtask

    task automatic check_tap(input string name, input int ch, input int exp);
        RD_ADDR = AW'(ch);
        @(negedge CLK);
        chk(name, 64'(RD_TAP), 64'(exp));
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        logic [EV_W-1:0] got;
        logic [EV_W-1:0] e;
        got = {DLY_LOAD, DLY_ADJ, DLY_INCDEC, DLY_LOAD_VALUE, ERR, SAT};
        if (RST === 1'b0 && got !== '0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got %h expected no activity", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL event: got %h expected %h", got, e);
                end
            end
        end
    end

    initial begin
        int n;
        int accepted;
        int strobes;
        int last;
        bit drop;

        RST = 1'b1;
        CMD_VALID = 1'b0;
        CMD_ADDR = '0;
        CMD_OP = '0;
        CMD_VALUE = '0;
        RD_ADDR = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 64'({DLY_LOAD, DLY_ADJ, DLY_INCDEC, DLY_LOAD_VALUE, RD_TAP, ERR, SAT, BUSY, CMD_READY} != '0), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 64'(CMD_READY), 64'd1);

        // LOAD ch7 = 33, then measure the re-accept distance
        send(7, OP_LOAD, 33, ev_load(7, 33), 1'b1);
        chk("busy_in_issue", 64'(BUSY), 64'd1);
        n = 1;
        while (CMD_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("reaccept_edges", 64'(n), 64'(2 + ST));
        check_tap("tap_ch7", 7, 33);
        check_tap("tap_out_of_range", 25, 0);

        // INC to max then saturate; read-during-update returns the old value
        send(2, OP_LOAD, 62, ev_load(2, 62), 1'b1);
        RD_ADDR = AW'(2);
        send(2, OP_INC, 0, ev_adj(2, 1'b1), 1'b1);
        chk("rd_pre_update", 64'(RD_TAP), 64'd62);
        @(negedge CLK);
        chk("rd_post_update", 64'(RD_TAP), 64'd63);
        send(2, OP_INC, 0, ev_flag(1'b0, 1'b1), 1'b1);
        chk("sat_keeps_ready", 64'(CMD_READY), 64'd1);
        check_tap("tap_ch2_sat", 2, 63);

        // DEC at zero saturates; INC/DEC walk ch0
        send(0, OP_DEC, 0, ev_flag(1'b0, 1'b1), 1'b1);
        send(0, OP_INC, 0, ev_adj(0, 1'b1), 1'b1);
        check_tap("tap_ch0_inc", 0, 1);
        send(0, OP_DEC, 0, ev_adj(0, 1'b0), 1'b1);
        check_tap("tap_ch0_dec", 0, 0);

        // Bad address and NOP
        send(20, OP_LOAD, 5, ev_flag(1'b1, 1'b0), 1'b1);
        chk("err_keeps_ready", 64'(CMD_READY), 64'd1);
        send(5, OP_NOP, 9, '0, 1'b0);
        chk("nop_not_busy", 64'(BUSY), 64'd0);
        check_tap("tap_ch5_nop", 5, 0);

        // Back-to-back INC on ch19 with CMD_VALID held
        wait_ready();
        for (int i = 0; i < 4; i++) exp_q.push_back(ev_adj(19, 1'b1));
        CMD_VALID = 1'b1;
        CMD_ADDR = AW'(19);
        CMD_OP = 2'(OP_INC);
        accepted = 0;
        strobes = 0;
        last = -1;
        drop = 1'b0;
        for (int c = 0; c < 60 && strobes < 4; c++) begin
            if (CMD_VALID && CMD_READY) begin
                accepted++;
                if (accepted == 4) drop = 1'b1;
            end
            @(negedge CLK);
            if (drop) CMD_VALID = 1'b0;
            if (DLY_ADJ[19]) begin
                if (last >= 0) chk("b2b_spacing", 64'(c - last), 64'(2 + ST));
                last = c;
                strobes++;
            end
        end
        CMD_VALID = 1'b0;
        chk("b2b_accepted", 64'(accepted), 64'd4);
        chk("b2b_strobes", 64'(strobes), 64'd4);
        wait_ready();
        check_tap("tap_ch19", 19, 4);

        // Reset during SETTLE after LOAD ch3 = 10
        send(3, OP_LOAD, 10, ev_load(3, 10), 1'b1);
        RD_ADDR = AW'(3);
        @(negedge CLK);
        chk("tap_before_reset", 64'(RD_TAP), 64'd10);
        chk("busy_in_settle", 64'(BUSY), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("reset_mid_outputs", 64'({DLY_LOAD, DLY_ADJ, DLY_INCDEC, DLY_LOAD_VALUE, RD_TAP, ERR, SAT, BUSY, CMD_READY} != '0), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_mid_reset", 64'(CMD_READY), 64'd1);
        chk("tap_ch3_reset", 64'(RD_TAP), 64'd0);

        repeat (10) @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
